// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART core: parity mode codes, oversampling
// factor, transmitter/receiver state encodings and the parity helper.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = 7;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Mode 11 is an alias for "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Callers zero-extend the data word; extra zero bits leave the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// ----------------------------------------------------------------------------
// uart_fifo
// Synchronous circular first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request and word (ignored when full, unless a pop
//                   happens in the same cycle)
//   pop             remove the head word (ignored when empty)
//   head            current head word
//   empty, full     status
//   count           occupancy 0..2^AW
// ----------------------------------------------------------------------------
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is accepted when a pop frees the head slot in
    // the same cycle; the write lands in that very slot, which becomes the tail.
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_core_v2.sv
// ----------------------------------------------------------------------------
// uart_core_v2
// Full-duplex UART with programmable 16x baud tick, parity, 1/2 stop bits,
// TX/RX FIFOs and sticky error flags.
// Ports:
//   clk_100MHz, reset_n          clock, asynchronous active-low reset
//   baud_div                     tick period minus one, in clocks
//   parity_mode, two_stop        frame format (sampled at each frame start)
//   rx / tx                      serial pins (tx idles high)
//   tx_data/tx_valid/tx_ready    TX FIFO push handshake
//   rx_data/rx_valid/rx_ready    RX FIFO pop handshake (fall-through head)
//   tx_count, rx_count           FIFO occupancy
//   tx_busy                      frame on the wire
//   frame_err/parity_err/overrun sticky flags, cleared by err_clear
// ----------------------------------------------------------------------------
module uart_core_v2 #(
    parameter int DBITS    = 8,
    parameter int FIFO_AW  = 4,
    parameter int DIV_BITS = 16
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    input  logic [DIV_BITS-1:0] baud_div,
    input  logic [1:0]          parity_mode,
    input  logic                two_stop,
    input  logic                rx,
    output logic                tx,
    input  logic [DBITS-1:0]    tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DBITS-1:0]    rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [FIFO_AW:0]    tx_count,
    output logic [FIFO_AW:0]    rx_count,
    output logic                tx_busy,
    output logic                frame_err,
    output logic                parity_err,
    output logic                overrun,
    input  logic                err_clear
);

    import uart_pkg::*;

    localparam logic [4:0] LAST_TICK  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_STOP2 = 5'(2 * OVERSAMPLE - 1);
    localparam logic [4:0] START_LAST = 5'(START_SAMPLE - 1);
    localparam logic [3:0] LAST_BIT   = 4'(DBITS - 1);

    logic [DIV_BITS-1:0] baud_cnt;
    logic                tick;

    logic [DBITS-1:0] tx_head;
    logic             tx_empty, tx_full, tx_pop;
    tx_state_t        tx_state;
    logic [DBITS-1:0] tx_shift;
    logic [4:0]       tx_ticks;
    logic [3:0]       tx_bit;
    logic             tx_par_en, tx_par, tx_two_stop;
    logic             tx_bit_end, tx_stop_end;

    logic             rx_s1, rx_s2;
    logic             rx_empty, rx_full, rx_pop, rx_push;
    rx_state_t        rx_state;
    logic [DBITS-1:0] rx_shift;
    logic [4:0]       rx_ticks;
    logic [3:0]       rx_bit;
    logic             rx_par_en, rx_odd, rx_par_bit, rx_sample;

    // Free-running tick counter; ">=" makes a shrinking baud_div wrap at once
    // instead of running the counter all the way around.
    assign tick = (baud_cnt >= baud_div);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)
            baud_cnt <= '0;
        else if (tick)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + DIV_BITS'(1);
    end

    uart_fifo #(.DATA_W(DBITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk_100MHz), .rst_n(reset_n),
        .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
        .head(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    assign tx_ready    = !tx_full;
    assign tx_bit_end  = tick && (tx_ticks == LAST_TICK);
    assign tx_stop_end = tick && (tx_ticks == (tx_two_stop ? LAST_STOP2 : LAST_TICK));
    // A new word is taken either from idle or on the final stop tick, which
    // is what lets consecutive frames run with no idle gap.
    assign tx_pop      = tick && !tx_empty &&
                         ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_stop_end));

    // Transmit FSM. tx and tx_busy are registered from the current state, so
    // the line trails the state by one clock uniformly across the frame.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_ticks    <= '0;
            tx_bit      <= '0;
            tx_par_en   <= 1'b0;
            tx_par      <= 1'b0;
            tx_two_stop <= 1'b0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            tx_busy <= (tx_state != TX_IDLE);
            if (tick)
                tx_ticks <= tx_ticks + 5'd1;
            case (tx_state)
                TX_IDLE: tx <= 1'b1;
                TX_START: begin
                    tx <= 1'b0;
                    if (tx_bit_end) begin
                        tx_ticks <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    tx <= tx_shift[0];
                    if (tx_bit_end) begin
                        tx_ticks <= '0;
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit == LAST_BIT)
                            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                        else
                            tx_bit <= tx_bit + 4'd1;
                    end
                end
                TX_PARITY: begin
                    tx <= tx_par;
                    if (tx_bit_end) begin
                        tx_ticks <= '0;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    tx <= 1'b1;
                    if (tx_stop_end) begin
                        tx_ticks <= '0;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
            if (tx_pop) begin
                tx_shift    <= tx_head;
                tx_par_en   <= parity_enabled(parity_mode);
                tx_par      <= parity_bit(9'(tx_head), parity_mode == PAR_ODD);
                tx_two_stop <= two_stop;
                tx_bit      <= '0;
                tx_ticks    <= '0;
                tx_state    <= TX_START;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    uart_fifo #(.DATA_W(DBITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk_100MHz), .rst_n(reset_n),
        .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
        .head(rx_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_sample = tick && (rx_ticks == LAST_TICK);

    // Receive FSM plus sticky flags. IDLE is only ever entered with the line
    // high, so a low level there is a falling edge. Flag sets are written
    // after the err_clear default so a coincident new error wins.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            rx_shift   <= '0;
            rx_ticks   <= '0;
            rx_bit     <= '0;
            rx_par_en  <= 1'b0;
            rx_odd     <= 1'b0;
            rx_par_bit <= 1'b0;
            rx_push    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (err_clear) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop)
                overrun <= 1'b1;
            if (tick)
                rx_ticks <= rx_ticks + 5'd1;
            case (rx_state)
                RX_IDLE: begin
                    rx_ticks <= '0;
                    if (!rx_s2) begin
                        rx_par_en <= parity_enabled(parity_mode);
                        rx_odd    <= (parity_mode == PAR_ODD);
                        rx_state  <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick && (rx_ticks == START_LAST)) begin
                        rx_ticks <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_ticks <= '0;
                        rx_shift <= {rx_s2, rx_shift[DBITS-1:1]};
                        if (rx_bit == LAST_BIT)
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                        else
                            rx_bit <= rx_bit + 4'd1;
                    end
                end
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_ticks   <= '0;
                        rx_par_bit <= rx_s2;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_sample) begin
                        rx_ticks <= '0;
                        if (!rx_s2) begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAIT_HIGH;
                        end else if (rx_par_en &&
                                     (rx_par_bit != parity_bit(9'(rx_shift), rx_odd))) begin
                            parity_err <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end else begin
                            rx_push  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s2)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core_v2.sv
// ----------------------------------------------------------------------------
// tb_uart_core_v2
// Directed self-checking bench for uart_core_v2: TX framing, parity and stop
// options, loopback into the RX FIFO, overrun, framing/parity errors, sticky
// flag clearing, glitch rejection, mid-frame reset and a baud change.
// ----------------------------------------------------------------------------
module tb_uart_core_v2;

    localparam int DBITS    = 8;
    localparam int FIFO_AW  = 4;
    localparam int DIV_BITS = 16;

    logic                clk_100MHz = 1'b0;
    logic                reset_n;
    logic [DIV_BITS-1:0] baud_div;
    logic [1:0]          parity_mode;
    logic                two_stop;
    logic                rx;
    logic                tx;
    logic [DBITS-1:0]    tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [DBITS-1:0]    rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [FIFO_AW:0]    tx_count;
    logic [FIFO_AW:0]    rx_count;
    logic                tx_busy;
    logic                frame_err;
    logic                parity_err;
    logic                overrun;
    logic                err_clear;

    logic                loopback;
    logic                rx_drive;
    logic [11:0]         bits;
    int                  busy;
    int                  lat;
    int                  wait_n;
    logic                seen;
    logic [7:0]          exp_word;
    int                  checks = 0;
    int                  errors = 0;

    uart_core_v2 #(.DBITS(DBITS), .FIFO_AW(FIFO_AW), .DIV_BITS(DIV_BITS)) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .baud_div(baud_div),
        .parity_mode(parity_mode), .two_stop(two_stop), .rx(rx), .tx(tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count), .tx_busy(tx_busy),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
        .err_clear(err_clear)
    );

    // 100 MHz clock.
    always #5 clk_100MHz = ~clk_100MHz;

    // The receiver listens either to the bench or to our own transmitter.
    assign rx = loopback ? tx : rx_drive;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // Push one word into the TX FIFO, waiting (bounded) for space.
    task automatic applyStimulus(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk_100MHz);
            n++;
        end
        if (n >= 3000)
            checkOutput("tx_ready_timeout", 32'd0, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_100MHz);
        tx_valid = 1'b0;
    endtask

    // Send one word and sample tx at every bit centre; bits[0] is the start bit.
    task automatic txFrame(input logic [7:0] d, input int period,
                           output logic [11:0] b, output int busy_cnt, output int latency);
        int i;
        int idx;
        b        = '1;
        busy_cnt = 0;
        latency  = 0;
        idx      = 0;
        applyStimulus(d);
        while (tx !== 1'b0 && latency < 40) begin
            @(negedge clk_100MHz);
            latency++;
        end
        i = 0;
        do begin
            if (tx_busy)
                busy_cnt++;
            if (i >= period / 2 && ((i - period / 2) % period) == 0 && idx < 12) begin
                b[idx] = tx;
                idx++;
            end
            @(negedge clk_100MHz);
            i++;
        end while (tx_busy && i < 2000);
    endtask

    // Bit-bang a frame onto rx at 32 clocks per bit (baud_div = 1).
    task automatic driveRxFrame(input logic [7:0] d, input logic has_par,
                                input logic par, input logic stop);
        rx_drive = 1'b0;
        waitCycles(32);
        for (int k = 0; k < 8; k++) begin
            rx_drive = d[k];
            waitCycles(32);
        end
        if (has_par) begin
            rx_drive = par;
            waitCycles(32);
        end
        rx_drive = stop;
        waitCycles(32);
        rx_drive = 1'b1;
        waitCycles(40);
    endtask

    // Hard stop if something hangs beyond any sane run length.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        baud_div    = 16'd1;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        rx_ready    = 1'b0;
        err_clear   = 1'b0;
        loopback    = 1'b0;
        rx_drive    = 1'b1;
        seen        = 1'b0;
        waitCycles(3);

        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_counts", {tx_count, rx_count}, 0);
        checkOutput("rst_flags", {frame_err, parity_err, overrun}, 0);
        reset_n = 1'b1;
        waitCycles(4);

        $display("[TB] 8N1 frame 0xA5");
        txFrame(8'hA5, 32, bits, busy, lat);
        checkOutput("8n1_latency_2to4", (lat >= 2 && lat <= 4), 1);
        checkOutput("8n1_bits", bits, 12'hF4A);
        checkOutput("8n1_busy", busy, 320);

        $display("[TB] even parity, two stop bits, 0x07");
        parity_mode = 2'b01;
        two_stop    = 1'b1;
        waitCycles(4);
        txFrame(8'h07, 32, bits, busy, lat);
        checkOutput("8e2_bits", bits, 12'hE0E);
        checkOutput("8e2_busy", busy, 384);

        $display("[TB] odd parity, one stop bit, 0x07");
        parity_mode = 2'b10;
        two_stop    = 1'b0;
        waitCycles(4);
        txFrame(8'h07, 32, bits, busy, lat);
        checkOutput("8o1_bits", bits, 12'hC0E);
        checkOutput("8o1_busy", busy, 352);

        $display("[TB] loopback fill, overrun, simultaneous pop/push");
        parity_mode = 2'b00;
        waitCycles(4);
        loopback = 1'b1;
        waitCycles(4);
        for (int k = 0; k < 18; k++)
            applyStimulus(8'(k));
        wait_n = 0;
        while (rx_count != 5'd16 && wait_n < 8000) begin
            @(negedge clk_100MHz);
            wait_n++;
        end
        checkOutput("lb_count16", rx_count, 16);
        checkOutput("lb_flags_clean", {frame_err, parity_err, overrun}, 0);
        waitCycles(330);
        checkOutput("lb_overrun_set", overrun, 1);
        checkOutput("lb_count_held", rx_count, 16);
        waitCycles(10);
        err_clear = 1'b1;
        waitCycles(1);
        err_clear = 1'b0;
        checkOutput("clear_flags", {frame_err, parity_err, overrun}, 0);
        waitCycles(298);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        checkOutput("popush_count", rx_count, 16);
        checkOutput("popush_no_overrun", overrun, 0);
        for (int k = 0; k < 16; k++) begin
            exp_word = (k < 15) ? 8'(k + 1) : 8'h11;
            checkOutput($sformatf("lb_data%0d", k), rx_data, exp_word);
            rx_ready = 1'b1;
            @(negedge clk_100MHz);
            rx_ready = 1'b0;
        end
        checkOutput("lb_drained", {rx_valid, rx_count}, 0);
        loopback = 1'b0;
        rx_drive = 1'b1;
        waitCycles(40);

        $display("[TB] framing and parity errors");
        driveRxFrame(8'h55, 1'b0, 1'b0, 1'b0);
        checkOutput("frame_err_set", frame_err, 1);
        checkOutput("frame_err_count", rx_count, 0);
        parity_mode = 2'b01;
        waitCycles(4);
        driveRxFrame(8'h07, 1'b1, 1'b0, 1'b1);
        checkOutput("parity_err_set", parity_err, 1);
        checkOutput("parity_err_count", rx_count, 0);
        driveRxFrame(8'h07, 1'b1, 1'b1, 1'b1);
        checkOutput("even_rx_count", rx_count, 1);
        checkOutput("even_rx_data", rx_data, 8'h07);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        err_clear = 1'b1;
        waitCycles(1);
        err_clear = 1'b0;
        checkOutput("clear_pulse", {frame_err, parity_err, overrun}, 0);

        $display("[TB] err_clear coinciding with a new framing error");
        parity_mode = 2'b00;
        waitCycles(4);
        fork
            driveRxFrame(8'h33, 1'b0, 1'b0, 1'b0);
            begin
                seen      = 1'b0;
                err_clear = 1'b1;
                for (int n = 0; n < 600; n++) begin
                    @(negedge clk_100MHz);
                    if (frame_err) begin
                        err_clear = 1'b0;
                        seen      = 1'b1;
                        break;
                    end
                end
                err_clear = 1'b0;
            end
        join
        waitCycles(5);
        checkOutput("clear_vs_set_seen", seen, 1);
        checkOutput("clear_vs_set_held", frame_err, 1);
        err_clear = 1'b1;
        waitCycles(1);
        err_clear = 1'b0;

        $display("[TB] start-bit glitch");
        rx_drive = 1'b0;
        waitCycles(4);
        rx_drive = 1'b1;
        waitCycles(80);
        checkOutput("glitch_count", rx_count, 0);
        checkOutput("glitch_flags", {frame_err, parity_err, overrun}, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h81);
        applyStimulus(8'h82);
        applyStimulus(8'h83);
        waitCycles(100);
        checkOutput("mid_busy", tx_busy, 1);
        checkOutput("mid_tx_count", tx_count, 2);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_tx", tx, 1);
        checkOutput("mid_rst_counts", {tx_count, rx_count}, 0);
        checkOutput("mid_rst_busy", tx_busy, 0);
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(4);
        txFrame(8'h3C, 32, bits, busy, lat);
        checkOutput("post_rst_bits", bits, 12'hE78);
        checkOutput("post_rst_busy", busy, 320);

        $display("[TB] baud_div 1 -> 3");
        baud_div = 16'd3;
        waitCycles(10);
        txFrame(8'h5A, 64, bits, busy, lat);
        checkOutput("baud3_bits", bits, 12'hEB4);
        checkOutput("baud3_busy", busy, 640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
